// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared encodings for the fetch-stage program-counter generator.
//
// Contents:
//   pc_state_e      : PC generator states (RESET / START / RUN)
//   CHIP_ENABLE     : instruction memory chip enable level
//   CHIP_DISABLE    : instruction memory chip disable level
//   STOP / NO_STOP  : stall vector bit levels
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_STATE_RESET = 2'd0,
    PC_STATE_START = 2'd1,
    PC_STATE_RUN   = 2'd2
  } pc_state_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf -- holds a branch target that arrived while the PC was
// stalled, until the stall releases.
//
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset (clears pend and pend_addr)
//   capture    in  store cap_addr and raise pend (a later capture overwrites)
//   clear      in  drop pend (wins over capture)
//   cap_addr   in  target to store, already aligned by the caller
//   pend_addr  out buffered target
//   pend       out a buffered target is waiting
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cap_addr,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (clear) begin
      pend <= 1'b0;
    end else if (capture) begin
      pend      <= 1'b1;
      pend_addr <= cap_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator at the head of the fetch stage.
// Produces the fetch address and the instruction-memory chip enable, with
// stall, branch redirect, buffered branch (branch during stall) and flush.
//
// Parameters:
//   ADDR_W     width of pc and redirect addresses
//   STEP       increment per fetch, power of two
//   RESET_VEC  first fetch address after reset
//   STALL_W    width of the pipeline stall vector (bit 0 is this stage)
//
// Ports:
//   clk            in  clock
//   rst_n          in  asynchronous active-low reset
//   stall          in  pipeline stall vector, only stall[0] is used
//   branch_flag    in  branch taken this cycle
//   branch_addr    in  branch target
//   flush          in  exception/flush redirect request
//   flush_addr     in  flush target
//   pc             out fetch address (registered)
//   ce             out instruction memory chip enable (registered)
//   redirect_pend  out buffered branch waiting for stall release (registered)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int unsigned       STEP      = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pend
);

  // Clears the low log2(STEP) bits of every captured redirect target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  pc_state_e         state;
  logic              run;
  logic              stall0;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_capture;
  logic              pend_clear;

  // Only stall[0] belongs to this stage; the rest of the vector is ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign stall0 = (stall[0] == STOP);
  assign run    = (state == PC_STATE_RUN);

  // Redirect priority: flush > branch (unstalled) > branch (stalled, buffer)
  // > buffered target on stall release > stall hold > sequential increment.
  // Redirect requests are ignored until the generator reaches RUN.
  always_comb begin
    pc_nxt       = pc;
    pend_capture = 1'b0;
    pend_clear   = 1'b0;
    if (run) begin
      if (flush) begin
        pc_nxt     = align_addr(flush_addr);
        pend_clear = 1'b1;
      end else if (branch_flag && !stall0) begin
        pc_nxt     = align_addr(branch_addr);
        pend_clear = 1'b1;
      end else if (branch_flag) begin
        pend_capture = 1'b1;
      end else if (redirect_pend && !stall0) begin
        pc_nxt     = pend_addr;
        pend_clear = 1'b1;
      end else if (!stall0) begin
        pc_nxt = pc + ADDR_W'(STEP);
      end
    end
  end

  // The async reset parks the FSM in START: the first edge after release
  // raises ce while pc keeps RESET_VEC, so RESET_VEC is the first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PC_STATE_START;
      ce    <= CHIP_DISABLE;
      pc    <= RESET_VEC;
    end else begin
      case (state)
        PC_STATE_RUN: pc <= pc_nxt;
        default: begin
          ce    <= CHIP_ENABLE;
          state <= PC_STATE_RUN;
        end
      endcase
    end
  end

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (pend_capture),
    .clear     (pend_clear),
    .cap_addr  (align_addr(branch_addr)),
    .pend_addr (pend_addr),
    .pend      (redirect_pend)
  );

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed bench for pc_gen with a behavioural reference model
// and hand-computed literal expectations.
module tb_pc_gen;

  localparam int          AW   = 32;
  localparam int unsigned STP  = 4;
  localparam logic [31:0] RV   = 32'h100;
  localparam logic [31:0] MASK = ~(32'(STP) - 32'd1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    stall;
  logic          branch_flag;
  logic [AW-1:0] branch_addr;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [AW-1:0] pc;
  logic          ce;
  logic          redirect_pend;

  // Narrow instance for wrap-around, free-running from reset.
  logic [5:0]    stall8 = '0;
  logic          bf8 = 1'b0;
  logic [7:0]    ba8 = '0;
  logic          fl8 = 1'b0;
  logic [7:0]    fa8 = '0;
  logic [7:0]    pc8;
  logic          ce8;
  logic          rp8;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pc_gen #(.ADDR_W(AW), .STEP(STP), .RESET_VEC(RV), .STALL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_flag(branch_flag),
    .branch_addr(branch_addr), .flush(flush), .flush_addr(flush_addr),
    .pc(pc), .ce(ce), .redirect_pend(redirect_pend)
  );

  pc_gen #(.ADDR_W(8), .STEP(1), .RESET_VEC(8'hFC), .STALL_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(stall8), .branch_flag(bf8),
    .branch_addr(ba8), .flush(fl8), .flush_addr(fa8),
    .pc(pc8), .ce(ce8), .redirect_pend(rp8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the redirect rules applied to the request seen at each edge.
  logic [31:0] m_pc = RV;
  logic        m_ce = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_paddr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RV; m_ce <= 1'b0; m_pend <= 1'b0; m_paddr <= '0;
    end else if (!m_ce) begin
      m_ce <= 1'b1;
    end else if (flush) begin
      m_pc <= flush_addr & MASK; m_pend <= 1'b0;
    end else if (branch_flag && !stall[0]) begin
      m_pc <= branch_addr & MASK; m_pend <= 1'b0;
    end else if (branch_flag) begin
      m_paddr <= branch_addr & MASK; m_pend <= 1'b1;
    end else if (m_pend && !stall[0]) begin
      m_pc <= m_paddr; m_pend <= 1'b0;
    end else if (!stall[0]) begin
      m_pc <= m_pc + 32'(STP);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_ce", {31'd0, ce}, {31'd0, m_ce});
      check("model_pend", {31'd0, redirect_pend}, {31'd0, m_pend});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = '0; branch_flag = 1'b0; branch_addr = '0;
    flush = 1'b0; flush_addr = '0;
    step(); step();
    check("rst_ce", {31'd0, ce}, 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_pend", {31'd0, redirect_pend}, 32'd0);
    chk_en = 1'b1;

    // Startup: ce rises on the first edge, pc holds RESET_VEC one more cycle.
    rst_n = 1'b1;
    step(); check("start_ce", {31'd0, ce}, 32'd1); check("start_pc0", pc, 32'h100);
    check("wrap_pc_fc", {24'd0, pc8}, 32'hFC);
    step(); check("start_pc1", pc, 32'h104); check("wrap_pc_fd", {24'd0, pc8}, 32'hFD);
    step(); check("start_pc2", pc, 32'h108); check("wrap_pc_fe", {24'd0, pc8}, 32'hFE);

    // Stall hold at 0x20, upper stall bits toggling.
    branch_flag = 1'b1; branch_addr = 32'h20;
    step(); check("br_pc20", pc, 32'h20); check("wrap_pc_ff", {24'd0, pc8}, 32'hFF);
    branch_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall = {5'($urandom_range(0, 31)), 1'b1};
      step(); check("stall_hold", pc, 32'h20);
      if (i == 0) check("wrap_pc_00", {24'd0, pc8}, 32'h00);
    end
    stall = 6'b111110;
    step(); check("stall_release", pc, 32'h24);
    stall = '0;

    // Buffered branch: two branches during stall, last one wins on release.
    branch_flag = 1'b1; branch_addr = 32'h40;
    step(); check("br_pc40", pc, 32'h40);
    stall = 6'd1; branch_addr = 32'h80;
    step(); check("buf_pc_a", pc, 32'h40); check("buf_pend_a", {31'd0, redirect_pend}, 32'd1);
    branch_addr = 32'h90;
    step(); check("buf_pc_b", pc, 32'h40); check("buf_pend_b", {31'd0, redirect_pend}, 32'd1);
    branch_flag = 1'b0;
    step(); check("buf_pc_c", pc, 32'h40);
    stall = '0;
    step(); check("buf_release", pc, 32'h90); check("buf_pend_clr", {31'd0, redirect_pend}, 32'd0);
    step(); check("buf_next", pc, 32'h94);

    // Priority: flush beats simultaneous branch and an existing pending target.
    stall = 6'd1; branch_flag = 1'b1; branch_addr = 32'h300;
    step(); check("prio_pend", {31'd0, redirect_pend}, 32'd1);
    flush = 1'b1; flush_addr = 32'h1000; branch_addr = 32'h200;
    step(); check("prio_pc", pc, 32'h1000); check("prio_pend_clr", {31'd0, redirect_pend}, 32'd0);
    flush = 1'b0; branch_flag = 1'b0; stall = '0;
    step(); check("prio_next", pc, 32'h1004);

    // Alignment of branch and flush targets.
    branch_flag = 1'b1; branch_addr = 32'h83;
    step(); check("align_branch", pc, 32'h80);
    branch_flag = 1'b0; flush = 1'b1; flush_addr = 32'h10A;
    step(); check("align_flush", pc, 32'h108);
    flush = 1'b0;
    step(); check("align_next", pc, 32'h10C);

    // Async reset mid-run while a branch is buffered.
    stall = 6'd1; branch_flag = 1'b1; branch_addr = 32'h500;
    step(); check("ar_pend", {31'd0, redirect_pend}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc", pc, 32'h100);
    check("ar_ce", {31'd0, ce}, 32'd0);
    check("ar_pend_clr", {31'd0, redirect_pend}, 32'd0);
    stall = '0; branch_flag = 1'b0;
    step();
    // Branch during the START edge is ignored.
    rst_n = 1'b1; branch_flag = 1'b1; branch_addr = 32'h700;
    step(); check("ign_ce", {31'd0, ce}, 32'd1); check("ign_pc", pc, 32'h100);
    branch_flag = 1'b0;
    step(); check("ign_next", pc, 32'h104);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
